// File: rtl/inverse_factorial.sv
// Inverse factorial unit: finds n with n! == x for a 16-bit x, or flags an
// error. Repeatedly divides x by 2, 3, 4, ... with a bit-serial restoring
// divider (one quotient bit per cycle, 16 cycles per division plus one
// check cycle). Shares the start/ready/done/error handshake of the factorial
// unit.
module inverse_factorial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x,
    output logic [7:0]  n,
    output logic        ready,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] q_reg;
    logic [7:0]  k_reg;
    logic [8:0]  r_reg;
    logic [3:0]  cnt;
    logic [7:0]  n_reg;

    logic        q_bit;
    logic [8:0]  r_step;
    logic [8:0]  k_inc;
    logic        q_too_small;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits.
    function automatic logic [9:0] div_step(input logic [7:0] r_low,
                                            input logic       msb,
                                            input logic [7:0] k);
        logic [8:0] t;
        t = {r_low, msb};
        if (t >= {1'b0, k})
            div_step = {1'b1, t - {1'b0, k}};
        else
            div_step = {1'b0, t};
    endfunction

    assign {q_bit, r_step} = div_step(r_reg[7:0], q_reg[15], k_reg);

    // 9-bit increment so the early-reject compare can never wrap
    assign k_inc       = {1'b0, k_reg} + 9'd1;
    assign q_too_small = (q_reg < {7'b0, k_inc});

    assign n = n_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and handshake decodes (state only)
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (x == 16'd0)
                        state_nxt = S_ERROR;
                    else if (x == 16'd1)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (cnt == 4'd0)
                    state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (r_reg != 9'd0)
                    state_nxt = S_ERROR;
                else if (q_reg == 16'd1)
                    state_nxt = S_DONE;
                else if (q_too_small)
                    state_nxt = S_ERROR;
                else
                    state_nxt = S_DIV;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                done      = 1'b1;
                error     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand latch, serial divider and divisor/result bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= 16'd0;
            k_reg <= 8'd0;
            r_reg <= 9'd0;
            cnt   <= 4'd0;
            n_reg <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        q_reg <= x;
                        n_reg <= 8'd0;
                        if (x == 16'd1) begin
                            n_reg <= 8'd1;
                        end else if (x != 16'd0) begin
                            k_reg <= 8'd2;
                            r_reg <= 9'd0;
                            cnt   <= 4'd15;
                        end
                    end
                end
                S_DIV: begin
                    q_reg <= {q_reg[14:0], q_bit};
                    r_reg <= r_step;
                    cnt   <= cnt - 4'd1;
                end
                S_CHECK: begin
                    if (r_reg == 9'd0) begin
                        if (q_reg == 16'd1) begin
                            n_reg <= k_reg;
                        end else if (!q_too_small) begin
                            k_reg <= k_reg + 8'd1;
                            r_reg <= 9'd0;
                            cnt   <= 4'd15;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inverse_factorial.sv
// Self-checking bench for inverse_factorial: directed cases, a mid-operation
// reset, and randomized operands compared against a factorial-table model.
module tb_inverse_factorial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [7:0]  n;
    logic        ready;
    logic        done;
    logic        error;

    int checks;
    int errors;
    int prev_n;

    inverse_factorial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .n     (n),
        .ready (ready),
        .done  (done),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result comes from the factorial table; the division count follows the
    // divide-by-2,3,4,... procedure with plain integer / and %.
    function automatic void model(input int xv, output int en, output int eerr,
                                  output int ed);
        int fact [8] = '{1, 2, 6, 24, 120, 720, 5040, 40320};
        int q;
        int k;
        en   = 0;
        eerr = 1;
        for (int i = 0; i < 8; i++)
            if (xv == fact[i]) begin
                en   = i + 1;
                eerr = 0;
            end
        ed = 0;
        if (xv >= 2) begin
            q = xv;
            k = 2;
            forever begin
                ed++;
                if (q % k != 0) break;
                q = q / k;
                if (q == 1) break;
                if (q < k + 1) break;
                k++;
            end
        end
    endfunction

    // Issue one request and check result, flags and latency
    task automatic run(input logic [15:0] xv, input bit inject);
        int en, ee, ed, c;
        bit seen;
        model(int'(xv), en, ee, ed);
        @(negedge clk);
        check("ready_idle", int'(ready), 1);
        check("n_hold", int'(n), prev_n);
        start = 1'b1;
        x     = xv;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = 16'($urandom);
        c     = 0;
        seen  = 1'b0;
        while (c < 200 && !seen) begin
            @(negedge clk);
            c++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (c == 1) begin
                    check("n_cleared", int'(n), 0);
                    check("ready_busy", int'(ready), 0);
                end
                if (inject && c == 5) begin
                    start = 1'b1;
                    x     = 16'd720;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check($sformatf("latency_x%0d", xv), c, 1 + 17 * ed);
        check($sformatf("n_x%0d", xv), int'(n), en);
        check($sformatf("error_x%0d", xv), int'(error), ee);
        @(negedge clk);
        check("done_pulse", int'(done), 0);
        prev_n = en;
    endtask

    initial begin
        int dcnt;
        int sel;
        int fact [8] = '{1, 2, 6, 24, 120, 720, 5040, 40320};
        logic [15:0] rx;
        checks = 0;
        errors = 0;
        prev_n = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        x      = 16'd0;
        #12;
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_n_out", int'(n), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(16'd40320, 1'b0);
        run(16'd720, 1'b0);
        run(16'd2, 1'b0);
        run(16'd1, 1'b0);
        run(16'd0, 1'b0);
        run(16'd121, 1'b0);
        run(16'd12, 1'b0);
        run(16'd30, 1'b0);
        run(16'd5040, 1'b1);
        run(16'd6, 1'b1);
        run(16'd65535, 1'b0);

        // Reset in the middle of a long division chain
        @(negedge clk);
        start = 1'b1;
        x     = 16'd40320;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", int'(ready), 1);
        check("midrst_n", int'(n), 0);
        check("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        prev_n = 0;
        run(16'd24, 1'b0);

        // Randomized operands biased toward factorials and their neighbours
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: rx = 16'(fact[$urandom_range(0, 7)]);
                1: rx = 16'(fact[$urandom_range(1, 7)] + ($urandom_range(0, 1) ? 1 : -1));
                2: rx = 16'($urandom_range(0, 50));
                default: rx = 16'($urandom);
            endcase
            run(rx, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
